// File: rtl/eth_tx_sched.sv
// eth_tx_sched: arbitrates eth_tx between ARP reply, ARP request and UDP,
// resolves the peer MAC with timed ARP retries, enforces IFG and watchdog.
module eth_tx_sched #(
  parameter int unsigned IFG_CYCLES  = 12,
  parameter int unsigned ARP_TIMEOUT = 125000000,
  parameter int unsigned ARP_RETRIES = 3,
  parameter int unsigned TX_TIMEOUT  = 4096
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       arp_resp_req,
  input  logic       mac_valid,
  input  logic       udp_req,
  input  logic       tx_done,
  output logic       arp_resp_ack,
  output logic       arp_tx_start,
  output logic       arp_oper,
  output logic       udp_tx_en,
  output logic       udp_tx_start,
  output logic       arp_fail,
  output logic       tx_err,
  output logic [1:0] retry_cnt
);

  typedef enum logic [2:0] {
    IDLE, ARP_RESP, ARP_RQ, UDP, GAP
  } state_t;

  typedef enum logic [1:0] {
    R_IDLE, R_WAIT, R_BACKOFF
  } rstate_t;

  localparam logic [31:0] LP_TMO   = 32'(ARP_TIMEOUT);
  localparam logic [31:0] LP_IFG_L = 32'(IFG_CYCLES - 1);
  localparam logic [31:0] LP_WD_L  = 32'(TX_TIMEOUT - 1);
  localparam logic [1:0]  LP_RET   = 2'(ARP_RETRIES);

  state_t      r_state, w_state_nx;
  logic [31:0] r_cnt, w_cnt_nx;
  logic        w_ack_nx, w_arp_st_nx, w_oper_nx;
  logic        w_en_nx, w_udp_st_nx, w_err_nx;
  logic        w_grant_rq, w_frame_end, w_rq_end;

  rstate_t     r_rstate, w_rstate_nx;
  logic        r_rq_pending, w_rqp_nx;
  logic [31:0] r_tmr, w_tmr_nx;
  logic        r_arm, w_arm_nx;
  logic [1:0]  w_retry_nx;
  logic        w_fail_nx;
  logic        w_expire;

  // r_cnt is the watchdog inside a frame and the gap counter in GAP
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_ack_nx    = 1'b0;
    w_arp_st_nx = 1'b0;
    w_oper_nx   = arp_oper;
    w_en_nx     = udp_tx_en;
    w_udp_st_nx = 1'b0;
    w_err_nx    = 1'b0;
    w_grant_rq  = 1'b0;
    w_frame_end = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nx = '0;
        if (arp_resp_req) begin
          w_state_nx  = ARP_RESP;
          w_ack_nx    = 1'b1;
          w_arp_st_nx = 1'b1;
          w_oper_nx   = 1'b0;
        end else if (r_rq_pending && !mac_valid) begin
          w_state_nx  = ARP_RQ;
          w_arp_st_nx = 1'b1;
          w_oper_nx   = 1'b1;
          w_grant_rq  = 1'b1;
        end else if (udp_req && mac_valid) begin
          w_state_nx  = UDP;
          w_udp_st_nx = 1'b1;
          w_en_nx     = 1'b1;
        end
      end
      ARP_RESP, ARP_RQ, UDP: begin
        if (tx_done || r_cnt == LP_WD_L) begin
          w_frame_end = 1'b1;
          w_state_nx  = GAP;
          w_cnt_nx    = '0;
          w_oper_nx   = 1'b0;
          w_en_nx     = 1'b0;
          w_err_nx    = !tx_done;
        end else begin
          w_cnt_nx = r_cnt + 32'd1;
        end
      end
      GAP: begin
        if (r_cnt == LP_IFG_L) begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 32'd1;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      arp_resp_ack <= 1'b0;
      arp_tx_start <= 1'b0;
      arp_oper     <= 1'b0;
      udp_tx_en    <= 1'b0;
      udp_tx_start <= 1'b0;
      tx_err       <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      arp_resp_ack <= w_ack_nx;
      arp_tx_start <= w_arp_st_nx;
      arp_oper     <= w_oper_nx;
      udp_tx_en    <= w_en_nx;
      udp_tx_start <= w_udp_st_nx;
      tx_err       <= w_err_nx;
    end
  end

  assign w_rq_end = w_frame_end && (r_state == ARP_RQ);
  // the timer is only meaningful once armed; it "reaches 0" on its 1 -> 0 step
  assign w_expire = r_arm && (r_tmr == 32'd1);

  always_comb begin
    w_rstate_nx = r_rstate;
    w_rqp_nx    = r_rq_pending && !w_grant_rq;
    w_retry_nx  = retry_cnt;
    w_tmr_nx    = (r_tmr != 32'd0) ? r_tmr - 32'd1 : r_tmr;
    w_arm_nx    = r_arm;
    w_fail_nx   = 1'b0;
    unique case (r_rstate)
      R_IDLE: begin
        if (udp_req && !mac_valid) begin
          w_rstate_nx = R_WAIT;
          w_rqp_nx    = 1'b1;
          w_retry_nx  = 2'd1;
          w_arm_nx    = 1'b0;
        end
      end
      R_WAIT: begin
        if (mac_valid) begin
          w_rstate_nx = R_IDLE;
          w_rqp_nx    = 1'b0;
          w_retry_nx  = 2'd0;
          w_arm_nx    = 1'b0;
        end else if (w_rq_end) begin
          w_tmr_nx = LP_TMO;
          w_arm_nx = 1'b1;
        end else if (w_expire) begin
          w_arm_nx = 1'b0;
          if (retry_cnt < LP_RET) begin
            w_rqp_nx   = 1'b1;
            w_retry_nx = retry_cnt + 2'd1;
          end else begin
            w_fail_nx   = 1'b1;
            w_rstate_nx = R_BACKOFF;
            w_retry_nx  = 2'd0;
            w_tmr_nx    = LP_TMO;
            w_arm_nx    = 1'b1;
          end
        end
      end
      R_BACKOFF: begin
        if (w_expire) begin
          w_rstate_nx = R_IDLE;
          w_arm_nx    = 1'b0;
        end
      end
      default: begin
        w_rstate_nx = R_IDLE;
        w_arm_nx    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rstate     <= R_IDLE;
      r_rq_pending <= 1'b0;
      r_tmr        <= '0;
      r_arm        <= 1'b0;
      retry_cnt    <= '0;
      arp_fail     <= 1'b0;
    end else begin
      r_rstate     <= w_rstate_nx;
      r_rq_pending <= w_rqp_nx;
      r_tmr        <= w_tmr_nx;
      r_arm        <= w_arm_nx;
      retry_cnt    <= w_retry_nx;
      arp_fail     <= w_fail_nx;
    end
  end

endmodule

// File: tb/tb_eth_tx_sched.sv
// tb_eth_tx_sched: directed checks of arbitration, IFG, ARP retry,
// watchdog and async reset for eth_tx_sched.
module tb_eth_tx_sched;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       arp_resp_req = 1'b0;
  logic       mac_valid = 1'b0;
  logic       udp_req = 1'b0;
  logic       tx_done = 1'b0;
  logic       arp_resp_ack;
  logic       arp_tx_start;
  logic       arp_oper;
  logic       udp_tx_en;
  logic       udp_tx_start;
  logic       arp_fail;
  logic       tx_err;
  logic [1:0] retry_cnt;

  int n_chk = 0;
  int n_pass = 0;
  int n;

  eth_tx_sched #(
    .IFG_CYCLES (12),
    .ARP_TIMEOUT(100),
    .ARP_RETRIES(3),
    .TX_TIMEOUT (64)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .arp_resp_req(arp_resp_req),
    .mac_valid   (mac_valid),
    .udp_req     (udp_req),
    .tx_done     (tx_done),
    .arp_resp_ack(arp_resp_ack),
    .arp_tx_start(arp_tx_start),
    .arp_oper    (arp_oper),
    .udp_tx_en   (udp_tx_en),
    .udp_tx_start(udp_tx_start),
    .arp_fail    (arp_fail),
    .tx_err      (tx_err),
    .retry_cnt   (retry_cnt)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return udp_tx_start;
      1:       return arp_tx_start;
      2:       return arp_fail;
      3:       return tx_err;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int lim, output int cnt);
    cnt = lim + 1;
    for (int i = 1; i <= lim; i++) begin
      tick();
      if (sig(sel)) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic count_starts(input int lim, output int cnt);
    cnt = 0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (udp_tx_start || arp_tx_start) cnt++;
    end
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic finish_frame();
    repeat (2) tick();
    pulse_done();
    repeat (14) tick();
  endtask

  function automatic logic [31:0] outs();
    return {23'd0, arp_resp_ack, arp_tx_start, arp_oper, udp_tx_en,
            udp_tx_start, arp_fail, tx_err, retry_cnt};
  endfunction

  initial begin
    repeat (3) tick();
    check("rst_outs", outs(), 0);
    aresetn = 1'b1;
    tick();
    check("idle_outs", outs(), 0);

    // UDP with resolved MAC, then back-to-back request behind the gap
    mac_valid = 1'b1;
    udp_req = 1'b1;
    tick();
    check("udp_start", udp_tx_start, 1);
    check("udp_en", udp_tx_en, 1);
    udp_req = 1'b0;
    tick();
    check("udp_start_pulse", udp_tx_start, 0);
    repeat (4) tick();
    check("udp_en_hold", udp_tx_en, 1);
    tx_done = 1'b1;
    udp_req = 1'b1;
    tick();
    tx_done = 1'b0;
    check("udp_en_drop", udp_tx_en, 0);
    wait_sig(0, 40, n);
    check("udp_ifg", n, 13);
    udp_req = 1'b0;
    finish_frame();

    // ARP reply beats UDP
    arp_resp_req = 1'b1;
    udp_req = 1'b1;
    tick();
    check("resp_ack", arp_resp_ack, 1);
    check("resp_start", arp_tx_start, 1);
    check("resp_oper", arp_oper, 0);
    check("resp_no_udp", udp_tx_start, 0);
    arp_resp_req = 1'b0;
    tick();
    check("resp_ack_pulse", arp_resp_ack, 0);
    check("resp_no_en", udp_tx_en, 0);
    pulse_done();
    wait_sig(0, 40, n);
    check("resp_then_udp", n, 13);
    udp_req = 1'b0;
    finish_frame();

    // unresolved MAC: three requests then arp_fail
    mac_valid = 1'b0;
    udp_req = 1'b1;
    tick();
    check("rq1_retry", retry_cnt, 1);
    check("rq1_lat", arp_tx_start, 0);
    tick();
    check("rq1_start", arp_tx_start, 1);
    check("rq1_oper", arp_oper, 1);
    for (int k = 2; k <= 3; k++) begin
      repeat (3) tick();
      check("rq_oper_hold", arp_oper, 1);
      pulse_done();
      wait_sig(1, 200, n);
      check("rq_spacing", n, 101);
      check("rq_retry", retry_cnt, k);
      check("rq_oper", arp_oper, 1);
    end
    repeat (3) tick();
    pulse_done();
    wait_sig(2, 200, n);
    check("fail_delay", n, 100);
    check("fail_retry", retry_cnt, 0);
    udp_req = 1'b0;
    tick();
    check("fail_pulse", arp_fail, 0);
    count_starts(120, n);
    check("fail_no_start", n, 0);

    // MAC resolves during the first wait
    udp_req = 1'b1;
    tick();
    tick();
    check("res_start", arp_tx_start, 1);
    check("res_retry", retry_cnt, 1);
    repeat (2) tick();
    pulse_done();
    repeat (49) tick();
    mac_valid = 1'b1;
    tick();
    check("res_udp", udp_tx_start, 1);
    check("res_retry0", retry_cnt, 0);
    udp_req = 1'b0;
    finish_frame();
    count_starts(120, n);
    check("res_no_rq", n, 0);

    // watchdog
    udp_req = 1'b1;
    tick();
    check("wd_start", udp_tx_start, 1);
    udp_req = 1'b0;
    wait_sig(3, 100, n);
    check("wd_delay", n, 64);
    check("wd_en", udp_tx_en, 0);
    udp_req = 1'b1;
    tick();
    check("wd_pulse", tx_err, 0);
    wait_sig(0, 40, n);
    check("wd_gap", n, 12);
    udp_req = 1'b0;
    finish_frame();

    // async reset in the middle of an ARP request frame
    mac_valid = 1'b0;
    udp_req = 1'b1;
    tick();
    tick();
    check("mid_start", arp_tx_start, 1);
    tick();
    check("mid_oper", arp_oper, 1);
    aresetn = 1'b0;
    #1;
    check("mid_rst_outs", outs(), 0);
    udp_req = 1'b0;
    mac_valid = 1'b1;
    tick();
    tick();
    aresetn = 1'b1;
    tick();
    check("post_rst_idle", outs(), 0);
    udp_req = 1'b1;
    tick();
    check("post_rst_udp", udp_tx_start, 1);
    check("post_rst_en", udp_tx_en, 1);
    udp_req = 1'b0;
    finish_frame();
    check("post_rst_done", udp_tx_en, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
